// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage forwarding selects and load-use interlock over a DEPTH-stage destination scoreboard
module hazard_scoreboard #(
  parameter int DEPTH = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W = 32,
  localparam int SELW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [31:0]      id_inst,
  input  logic             hold,
  input  logic             flush,
  output logic [SELW-1:0]  fwd_sel_1,
  output logic [SELW-1:0]  fwd_sel_2,
  output logic             stall,
  output logic [CNT_W-1:0] stall_cnt
);
  localparam logic [6:0] op_r = 7'b0110011, op_i = 7'b0010011, op_ld = 7'b0000011,
    op_st = 7'b0100011, op_br = 7'b1100011, op_jalr = 7'b1100111, op_csr = 7'b1110011,
    op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111;
  logic [6:0] op;
  logic [4:0] rd, rs1, rs2;
  logic use_1, use_2, writes, is_load, ld_hit_1, ld_hit_2;
  logic [DEPTH:1] v, ld;
  logic [4:0] dst [DEPTH:1];
  logic unused_bits;
  assign op = id_inst[6:0];
  assign rd = id_inst[11:7];
  assign rs1 = id_inst[19:15];
  assign rs2 = id_inst[24:20];
  assign unused_bits = ^{id_inst[31:25], id_inst[14:12]};
  assign use_1 = op inside {op_r, op_i, op_ld, op_st, op_br, op_jalr, op_csr};
  assign use_2 = op inside {op_r, op_st, op_br};
  assign writes = op inside {op_r, op_i, op_ld, op_lui, op_auipc, op_jal, op_jalr};
  assign is_load = op == op_ld;
  // scan oldest to youngest so the youngest match overwrites
  always_comb begin
    fwd_sel_1 = '0;
    fwd_sel_2 = '0;
    ld_hit_1 = 1'b0;
    ld_hit_2 = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (v[k] && dst[k] != 5'd0 && dst[k] == rs1 && use_1 && id_valid) begin
        fwd_sel_1 = SELW'(k);
        ld_hit_1 = ld[k] && k <= LOAD_LAT;
      end
      if (v[k] && dst[k] != 5'd0 && dst[k] == rs2 && use_2 && id_valid) begin
        fwd_sel_2 = SELW'(k);
        ld_hit_2 = ld[k] && k <= LOAD_LAT;
      end
    end
  end
  assign stall = ld_hit_1 | ld_hit_2;
  always_ff @(posedge clk) begin
    if (!rst) begin
      v <= '0;
      stall_cnt <= '0;
    end else if (!hold) begin
      v <= {v[DEPTH-1:1] & {(DEPTH-1){!flush}}, id_valid && writes && !stall && !flush};
      if (stall && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (rst && !hold) begin
      ld <= {ld[DEPTH-1:1], is_load};
      dst[1] <= rd;
      for (int k = 2; k <= DEPTH; k++) dst[k] <= dst[k-1];
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: vector table, corner sequences and random traffic against a stage-list model
module tb_hazard_scoreboard;
  localparam int D = 3, LL = 1, CW = 4;
  localparam logic [6:0] op_r = 7'b0110011, op_i = 7'b0010011, op_ld = 7'b0000011,
    op_st = 7'b0100011, op_br = 7'b1100011, op_jalr = 7'b1100111, op_csr = 7'b1110011,
    op_lui = 7'b0110111, op_auipc = 7'b0010111, op_jal = 7'b1101111;
  logic clk = 0, rst = 0, id_valid = 0, hold = 0, flush = 0;
  logic [31:0] id_inst = '0;
  logic [1:0] fwd_sel_1, fwd_sel_2;
  logic stall;
  logic [CW-1:0] stall_cnt;
  int checks = 0, fails = 0;
  bit mv [1:D];
  int mrd [1:D];
  bit mld [1:D];
  int mcnt = 0;
  bit m_es;
  typedef struct { logic [31:0] inst; bit val; int f1, f2, st, cnt; } vec_t;
  vec_t tbl [$];
  logic [6:0] ops [10] = '{op_r, op_i, op_ld, op_st, op_br, op_jalr, op_csr, op_lui, op_auipc, op_jal};

  always #5 clk = ~clk;

  hazard_scoreboard #(.DEPTH(D), .LOAD_LAT(LL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_inst(id_inst), .hold(hold), .flush(flush),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .stall(stall), .stall_cnt(stall_cnt));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(logic [6:0] op, int rd, int rs1, int rs2);
    return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), op};
  endfunction

  function automatic void dec(logic [31:0] i, output bit u1, u2, wr, isl);
    u1 = i[6:0] inside {op_r, op_i, op_ld, op_st, op_br, op_jalr, op_csr};
    u2 = i[6:0] inside {op_r, op_st, op_br};
    wr = i[6:0] inside {op_r, op_i, op_ld, op_lui, op_auipc, op_jal, op_jalr};
    isl = i[6:0] == op_ld;
  endfunction

  function automatic int youngest(int rs, bit uses);
    if (!id_valid || !uses || rs == 0) return 0;
    for (int k = 1; k <= D; k++) if (mv[k] && mrd[k] == rs) return k;
    return 0;
  endfunction

  function automatic bit too_early(int k);
    return k != 0 && mld[k] && k < 1 + LL;
  endfunction

  task automatic apply(logic [31:0] inst, bit val = 1, bit h = 0, bit f = 0, bit r = 1);
    bit u1, u2, wr, isl;
    int e1, e2;
    id_inst = inst; id_valid = val; hold = h; flush = f; rst = r;
    #1;
    dec(inst, u1, u2, wr, isl);
    e1 = youngest(int'(inst[19:15]), u1);
    e2 = youngest(int'(inst[24:20]), u2);
    m_es = too_early(e1) || too_early(e2);
    chk("model_fwd1", fwd_sel_1, e1);
    chk("model_fwd2", fwd_sel_2, e2);
    chk("model_stall", stall, m_es);
    chk("model_cnt", stall_cnt, mcnt);
  endtask

  task automatic tick();
    bit u1, u2, wr, isl;
    @(posedge clk);
    dec(id_inst, u1, u2, wr, isl);
    if (!rst) begin
      for (int k = 1; k <= D; k++) mv[k] = 0;
      mcnt = 0;
    end else if (!hold) begin
      if (m_es && !flush && mcnt < (1 << CW) - 1) mcnt++;
      for (int k = D; k >= 2; k--) begin
        mv[k] = mv[k-1] && !flush;
        mrd[k] = mrd[k-1];
        mld[k] = mld[k-1];
      end
      mv[1] = id_valid && wr && id_inst[11:7] != 0 && !m_es && !flush;
      mrd[1] = int'(id_inst[11:7]);
      mld[1] = isl;
    end
    #1;
  endtask

  initial begin
    logic [31:0] nop, cons, use8;
    nop = enc(op_i, 0, 0, 0);
    cons = enc(op_r, 6, 5, 5);
    use8 = enc(op_i, 9, 8, 1);
    apply(cons, 1, 1, 1, 0); tick();
    apply(cons);
    chk("reset_fwd1", fwd_sel_1, 0); chk("reset_fwd2", fwd_sel_2, 0);
    chk("reset_stall", stall, 0); chk("reset_cnt", stall_cnt, 0);
    tick();
    apply(nop); tick();
    tbl.push_back('{enc(op_r, 5, 1, 2), 1, 0, 0, 0, 0});
    tbl.push_back('{cons, 1, 1, 1, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{enc(op_r, 5, 1, 2), 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{enc(op_r, 7, 5, 0), 1, 2, 0, 0, 0});
    tbl.push_back('{enc(op_r, 5, 1, 2), 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{nop, 1, 0, 0, 0, 0});
    tbl.push_back('{enc(op_r, 7, 5, 0), 1, 0, 0, 0, 0});
    tbl.push_back('{enc(op_ld, 8, 1, 0), 1, 0, 0, 0, 0});
    tbl.push_back('{use8, 1, 1, 0, 1, 0});
    tbl.push_back('{use8, 1, 2, 0, 0, 1});
    tbl.push_back('{enc(op_i, 3, 0, 1), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_i, 3, 0, 2), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_r, 10, 3, 3), 1, 1, 1, 0, 1});
    tbl.push_back('{enc(op_r, 0, 1, 2), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_r, 11, 0, 0), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_lui, 4, 0, 0), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_st, 0, 1, 4), 1, 0, 1, 0, 1});
    tbl.push_back('{enc(op_br, 0, 1, 4), 1, 0, 2, 0, 1});
    tbl.push_back('{enc(op_r, 6, 4, 4), 0, 0, 0, 0, 1});
    tbl.push_back('{enc(op_ld, 8, 1, 0), 1, 0, 0, 0, 1});
    tbl.push_back('{enc(op_st, 0, 2, 8), 1, 0, 1, 1, 1});
    tbl.push_back('{enc(op_st, 0, 2, 8), 1, 0, 2, 0, 2});
    foreach (tbl[i]) begin
      apply(tbl[i].inst, tbl[i].val);
      chk($sformatf("vec%0d_fwd1", i), fwd_sel_1, tbl[i].f1);
      chk($sformatf("vec%0d_fwd2", i), fwd_sel_2, tbl[i].f2);
      chk($sformatf("vec%0d_stall", i), stall, tbl[i].st);
      chk($sformatf("vec%0d_cnt", i), stall_cnt, tbl[i].cnt);
      tick();
    end
    apply(nop, 1, 0, 0, 0); tick();
    apply(enc(op_ld, 8, 1, 0)); tick();
    for (int i = 0; i < 4; i++) begin
      apply(use8, 1, 1);
      chk("hold_stall", stall, 1); chk("hold_fwd1", fwd_sel_1, 1); chk("hold_cnt", stall_cnt, 0);
      tick();
    end
    apply(use8);
    chk("unhold_stall", stall, 1); chk("unhold_cnt", stall_cnt, 0);
    tick();
    apply(use8);
    chk("after_hold_stall", stall, 0); chk("after_hold_fwd1", fwd_sel_1, 2); chk("after_hold_cnt", stall_cnt, 1);
    tick();
    for (int i = 0; i < 3; i++) begin apply(enc(op_r, 5, 1, 2)); tick(); end
    apply(cons, 1, 0, 1);
    chk("preflush_fwd1", fwd_sel_1, 1);
    tick();
    apply(cons);
    chk("flush_fwd1", fwd_sel_1, 0); chk("flush_fwd2", fwd_sel_2, 0);
    tick();
    apply(enc(op_ld, 8, 1, 0)); tick();
    apply(use8, 1, 0, 1);
    chk("flush_stall_stall", stall, 1);
    tick();
    apply(use8);
    chk("flush_kill_stall", stall, 0); chk("flush_kill_fwd1", fwd_sel_1, 0); chk("flush_nocount", stall_cnt, 1);
    tick();
    apply(enc(op_ld, 8, 1, 0)); tick();
    apply(use8, 1, 1, 0, 0);
    chk("prereset_stall", stall, 1);
    tick();
    apply(use8);
    chk("midreset_stall", stall, 0); chk("midreset_cnt", stall_cnt, 0); chk("midreset_fwd1", fwd_sel_1, 0);
    tick();
    for (int i = 0; i < 17; i++) begin
      apply(enc(op_ld, 8, 1, 0)); tick();
      apply(use8); tick();
      apply(use8); tick();
    end
    apply(nop);
    chk("saturate_cnt", stall_cnt, 15);
    tick();
    for (int i = 0; i < 3000; i++) begin
      apply(enc(ops[$urandom_range(0, 9)], $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
            $urandom_range(0, 9) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
            $urandom_range(0, 99) != 0);
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
